// File: rtl/ex_stage_pkg.sv
// ex_stage_pkg: shared definitions for the execute stage.
//   - bus widths, StallBus width and Stop/NoStop levels
//   - ALU operation codes and divide operation codes
//   - ID/EX register layout as a packed struct, divider FSM state type
//   - abs32(): magnitude of a two's-complement word
package ex_stage_pkg;

    // The ID->EX field list (pc, alu_op, div_op, four control bits,
    // rf_waddr, src_a, src_b, store_data) sums to 143 bits; the bus width
    // is sized to hold every field.
    localparam int ID_TO_EX_WD  = 143;
    localparam int EX_TO_MEM_WD = 76;
    localparam int EX_TO_RF_WD  = 38;
    localparam int STALL_BUS_WD = 6;
    localparam int DIV_CYCLES   = 32;

    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_NOR  = 4'd5;
    localparam logic [3:0] ALU_SLT  = 4'd6;
    localparam logic [3:0] ALU_SLTU = 4'd7;
    localparam logic [3:0] ALU_SLL  = 4'd8;
    localparam logic [3:0] ALU_SRL  = 4'd9;
    localparam logic [3:0] ALU_SRA  = 4'd10;
    localparam logic [3:0] ALU_LUI  = 4'd11;
    localparam logic [3:0] ALU_MFHI = 4'd12;
    localparam logic [3:0] ALU_MFLO = 4'd13;

    localparam logic [1:0] DIV_NONE = 2'b00;
    localparam logic [1:0] DIV_S    = 2'b10;
    localparam logic [1:0] DIV_U    = 2'b11;

    typedef struct packed {
        logic [31:0] pc;
        logic [3:0]  alu_op;
        logic [1:0]  div_op;
        logic        mem_en;
        logic        mem_we;
        logic        sel_rf_res;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic [31:0] src_a;
        logic [31:0] src_b;
        logic [31:0] store_data;
    } id_to_ex_t;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

    function automatic logic [31:0] abs32(input logic [31:0] v);
        return v[31] ? (32'd0 - v) : v;
    endfunction

endpackage

// File: rtl/ex_stage_div.sv
// div_unit: iterative 32-step restoring divider.
//   clk, rst      : clock, synchronous active-low reset (abandons a divide)
//   load          : ID/EX register takes a new value (re-arms the start)
//   div_op        : 10 DIV signed, 11 DIVU, 00/01 no divide
//   src_a, src_b  : dividend, divisor
//   busy          : stall request (start cycle plus every BUSY cycle)
//   ready         : one-cycle commit strobe in DONE
//   quotient, remainder : sign-corrected results, valid while ready
module div_unit
    import ex_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [1:0]  div_op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    output logic        busy,
    output logic        ready,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);

    localparam int CNT_WD = $clog2(DIV_CYCLES);
    localparam logic [CNT_WD-1:0] LAST_STEP = CNT_WD'(DIV_CYCLES - 1);

    div_state_e        state_r;
    logic [CNT_WD-1:0] count_r;
    logic [31:0]       rem_r;
    logic [31:0]       quo_r;
    logic [31:0]       divisor_r;
    logic [31:0]       raw_dividend_r;
    logic              q_neg_r;
    logic              r_neg_r;
    logic              by_zero_r;
    logic              started_r;

    logic              is_signed_s;
    logic              start_s;
    logic [32:0]       shifted_s;
    logic [32:0]       diff_s;
    logic              ge_s;

    assign is_signed_s = (div_op == DIV_S);
    // Only the first IDLE cycle of a given instruction may launch a divide.
    assign start_s = (state_r == DIV_IDLE) && div_op[1] && !started_r;

    // One restoring step: shift in the next dividend bit, trial-subtract.
    always_comb begin
        shifted_s = {rem_r, quo_r[31]};
        diff_s    = shifted_s - {1'b0, divisor_r};
        ge_s      = ~diff_s[32];
    end

    // Divider FSM, operand latch and iteration registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r        <= DIV_IDLE;
            count_r        <= '0;
            rem_r          <= 32'd0;
            quo_r          <= 32'd0;
            divisor_r      <= 32'd0;
            raw_dividend_r <= 32'd0;
            q_neg_r        <= 1'b0;
            r_neg_r        <= 1'b0;
            by_zero_r      <= 1'b0;
            started_r      <= 1'b0;
        end else begin
            if (load) begin
                started_r <= 1'b0;
            end else if (start_s) begin
                started_r <= 1'b1;
            end
            case (state_r)
                DIV_IDLE: begin
                    if (start_s) begin
                        q_neg_r        <= is_signed_s && (src_a[31] ^ src_b[31]);
                        r_neg_r        <= is_signed_s && src_a[31];
                        quo_r          <= is_signed_s ? abs32(src_a) : src_a;
                        divisor_r      <= is_signed_s ? abs32(src_b) : src_b;
                        rem_r          <= 32'd0;
                        raw_dividend_r <= src_a;
                        by_zero_r      <= (src_b == 32'd0);
                        count_r        <= '0;
                        state_r        <= DIV_BUSY;
                    end
                end
                DIV_BUSY: begin
                    rem_r   <= ge_s ? diff_s[31:0] : shifted_s[31:0];
                    quo_r   <= {quo_r[30:0], ge_s};
                    count_r <= count_r + CNT_WD'(1);
                    if (count_r == LAST_STEP) begin
                        state_r <= DIV_DONE;
                    end
                end
                DIV_DONE: state_r <= DIV_IDLE;
                default:  state_r <= DIV_IDLE;
            endcase
        end
    end

    // Sign fix-up and divide-by-zero override on the final magnitudes.
    always_comb begin
        if (by_zero_r) begin
            quotient  = 32'hFFFF_FFFF;
            remainder = raw_dividend_r;
        end else begin
            quotient  = q_neg_r ? (32'd0 - quo_r) : quo_r;
            remainder = r_neg_r ? (32'd0 - rem_r) : rem_r;
        end
    end

    assign busy  = start_s || (state_r == DIV_BUSY);
    assign ready = (state_r == DIV_DONE);

endmodule

// File: rtl/ex_stage.sv
// ex_stage: execute stage between ID and MEM.
//   clk, rst        : clock, synchronous active-low reset
//   stall           : StallBus, bit 2 = EX input, bit 3 = MEM input (1 = Stop)
//   id_to_ex_bus    : decoded instruction from ID
//   ex_to_mem_bus   : {pc, data_ram_en, data_ram_wen, sel_rf_res, rf_we, rf_waddr, ex_result}
//   ex_to_rf_bus    : {rf_we, rf_waddr, ex_result} forwarding to ID
//   stallreq_for_ex : divider busy
//   data_sram_*     : data SRAM request
module ex_stage
    import ex_stage_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic [STALL_BUS_WD-1:0] stall,
    input  logic [ID_TO_EX_WD-1:0]  id_to_ex_bus,
    output logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
    output logic [EX_TO_RF_WD-1:0]  ex_to_rf_bus,
    output logic                    stallreq_for_ex,
    output logic                    data_sram_en,
    output logic [3:0]              data_sram_wen,
    output logic [31:0]             data_sram_addr,
    output logic [31:0]             data_sram_wdata
);

    id_to_ex_t   id_ex_r;
    logic [31:0] hi_r;
    logic [31:0] lo_r;

    logic        bubble_s;
    logic        load_s;
    logic [31:0] src_a_s;
    logic [31:0] src_b_s;
    logic [31:0] alu_res_s;
    logic [31:0] ex_result_s;
    logic        div_ready_s;
    logic [31:0] div_quo_s;
    logic [31:0] div_rem_s;

    assign bubble_s = (stall[2] == STOP) && (stall[3] == NO_STOP);
    assign load_s   = bubble_s || (stall[2] == NO_STOP);

    // ID/EX pipeline register: bubble, load or hold.
    always_ff @(posedge clk) begin
        if (!rst) begin
            id_ex_r <= '0;
        end else if (bubble_s) begin
            id_ex_r <= '0;
        end else if (stall[2] == NO_STOP) begin
            id_ex_r <= id_to_ex_bus;
        end else begin
            id_ex_r <= id_ex_r;
        end
    end

    assign src_a_s = id_ex_r.src_a;
    assign src_b_s = id_ex_r.src_b;

    // ALU on the registered operands; shift amount comes from src_a.
    always_comb begin
        alu_res_s = 32'd0;
        case (id_ex_r.alu_op)
            ALU_ADD:  alu_res_s = src_a_s + src_b_s;
            ALU_SUB:  alu_res_s = src_a_s - src_b_s;
            ALU_AND:  alu_res_s = src_a_s & src_b_s;
            ALU_OR:   alu_res_s = src_a_s | src_b_s;
            ALU_XOR:  alu_res_s = src_a_s ^ src_b_s;
            ALU_NOR:  alu_res_s = ~(src_a_s | src_b_s);
            ALU_SLT:  alu_res_s = {31'd0, ($signed(src_a_s) < $signed(src_b_s))};
            ALU_SLTU: alu_res_s = {31'd0, (src_a_s < src_b_s)};
            ALU_SLL:  alu_res_s = src_b_s << src_a_s[4:0];
            ALU_SRL:  alu_res_s = src_b_s >> src_a_s[4:0];
            ALU_SRA:  alu_res_s = $unsigned($signed(src_b_s) >>> src_a_s[4:0]);
            ALU_LUI:  alu_res_s = {src_b_s[15:0], 16'h0000};
            ALU_MFHI: alu_res_s = hi_r;
            ALU_MFLO: alu_res_s = lo_r;
            default:  alu_res_s = 32'd0;
        endcase
    end

    // Divide instructions produce no register-file result.
    always_comb begin
        if (id_ex_r.div_op[1]) begin
            ex_result_s = 32'd0;
        end else begin
            ex_result_s = alu_res_s;
        end
    end

    div_unit u_div (
        .clk       (clk),
        .rst       (rst),
        .load      (load_s),
        .div_op    (id_ex_r.div_op),
        .src_a     (src_a_s),
        .src_b     (src_b_s),
        .busy      (stallreq_for_ex),
        .ready     (div_ready_s),
        .quotient  (div_quo_s),
        .remainder (div_rem_s)
    );

    // HI/LO commit once, in the divider's DONE cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            hi_r <= 32'd0;
            lo_r <= 32'd0;
        end else if (div_ready_s) begin
            hi_r <= div_rem_s;
            lo_r <= div_quo_s;
        end else begin
            hi_r <= hi_r;
            lo_r <= lo_r;
        end
    end

    assign data_sram_en    = id_ex_r.mem_en;
    assign data_sram_wen   = id_ex_r.mem_we ? 4'b1111 : 4'b0000;
    assign data_sram_addr  = ex_result_s;
    assign data_sram_wdata = id_ex_r.store_data;

    assign ex_to_mem_bus = {id_ex_r.pc, data_sram_en, data_sram_wen, id_ex_r.sel_rf_res,
                            id_ex_r.rf_we, id_ex_r.rf_waddr, ex_result_s};
    assign ex_to_rf_bus  = {id_ex_r.rf_we, id_ex_r.rf_waddr, ex_result_s};

endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: self-checking bench for ex_stage with a behavioural model.
module tb_ex_stage;
    import ex_stage_pkg::*;

    localparam logic [5:0] ST_RUN    = 6'b000000;
    localparam logic [5:0] ST_HOLD   = 6'b001111;
    localparam logic [5:0] ST_BUBBLE = 6'b000111;

    logic                    clk;
    logic                    rst;
    logic [5:0]              stall;
    logic [ID_TO_EX_WD-1:0]  id_to_ex_bus;
    logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus;
    logic [37:0]             ex_to_rf_bus;
    logic                    stallreq_for_ex;
    logic                    data_sram_en;
    logic [3:0]              data_sram_wen;
    logic [31:0]             data_sram_addr;
    logic [31:0]             data_sram_wdata;

    int          checks;
    int          errors;
    logic [31:0] hi_m;
    logic [31:0] lo_m;

    ex_stage dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .id_to_ex_bus    (id_to_ex_bus),
        .ex_to_mem_bus   (ex_to_mem_bus),
        .ex_to_rf_bus    (ex_to_rf_bus),
        .stallreq_for_ex (stallreq_for_ex),
        .data_sram_en    (data_sram_en),
        .data_sram_wen   (data_sram_wen),
        .data_sram_addr  (data_sram_addr),
        .data_sram_wdata (data_sram_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [ID_TO_EX_WD-1:0] mk_bus(
        input logic [31:0] pc, input logic [3:0] op, input logic [1:0] dop,
        input logic men, input logic mwe, input logic sel, input logic we,
        input logic [4:0] wa, input logic [31:0] a, input logic [31:0] b,
        input logic [31:0] sd);
        return {pc, op, dop, men, mwe, sel, we, wa, a, b, sd};
    endfunction

    function automatic logic [EX_TO_MEM_WD-1:0] exp_mem(
        input logic [31:0] pc, input logic men, input logic mwe, input logic sel,
        input logic we, input logic [4:0] wa, input logic [31:0] res);
        return {pc, men, (mwe ? 4'hF : 4'h0), sel, we, wa, res};
    endfunction

    function automatic logic [31:0] model_alu(input logic [3:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        longint unsigned ub;
        longint unsigned p2;
        logic [31:0]     nb;
        logic [31:0]     r;
        ub = {32'd0, b};
        p2 = 64'd1 << a[4:0];
        nb = ~b;
        case (op)
            4'd0:    r = a + b;
            4'd1:    r = a - b;
            4'd2:    r = a & b;
            4'd3:    r = a | b;
            4'd4:    r = a ^ b;
            4'd5:    r = ~(a | b);
            4'd6:    r = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            4'd7:    r = (a < b) ? 32'd1 : 32'd0;
            4'd8:    r = 32'(ub * p2);
            4'd9:    r = 32'(ub / p2);
            4'd10:   r = b[31] ? ~32'({32'd0, nb} / p2) : 32'(ub / p2);
            4'd11:   r = 32'(ub * 64'd65536);
            4'd12:   r = hi_m;
            4'd13:   r = lo_m;
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    task automatic model_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                             output logic [31:0] q, output logic [31:0] r);
        longint sa;
        longint sb;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else begin
            if (op == DIV_S) begin
                sa = longint'(int'(a));
                sb = longint'(int'(b));
            end else begin
                sa = longint'({32'd0, a});
                sb = longint'({32'd0, b});
            end
            q = 32'(sa / sb);
            r = 32'(sa % sb);
        end
    endtask

    // Runs one divide with a stall controller that holds EX while stallreq is high,
    // keeps the instruction one extra cycle after completion, then reads LO and HI.
    task automatic run_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                           output int cycles, output logic [31:0] res_busy,
                           output logic retrig, output logic [31:0] lo_seen,
                           output logic [31:0] hi_seen);
        id_to_ex_bus = mk_bus(32'h0000_2000, ALU_ADD, op, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,
                              a, b, 32'd0);
        stall = ST_RUN;
        @(negedge clk);
        res_busy = ex_to_rf_bus[31:0];
        cycles = 0;
        while (stallreq_for_ex === 1'b1 && cycles < 100) begin
            stall = ST_HOLD;
            cycles++;
            @(negedge clk);
        end
        stall = ST_HOLD;
        @(negedge clk);
        retrig = stallreq_for_ex;
        id_to_ex_bus = mk_bus(32'h0000_2004, ALU_MFLO, DIV_NONE, 1'b0, 1'b0, 1'b1, 1'b1, 5'd8,
                              32'd0, 32'd0, 32'd0);
        stall = ST_RUN;
        @(negedge clk);
        lo_seen = ex_to_rf_bus[31:0];
        id_to_ex_bus = mk_bus(32'h0000_2008, ALU_MFHI, DIV_NONE, 1'b0, 1'b0, 1'b1, 1'b1, 5'd9,
                              32'd0, 32'd0, 32'd0);
        @(negedge clk);
        hi_seen = ex_to_rf_bus[31:0];
    endtask

    task automatic test_reset();
        logic [159:0] rnd;
        rnd = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        rst = 1'b0;
        stall = ST_RUN;
        id_to_ex_bus = rnd[ID_TO_EX_WD-1:0];
        repeat (2) @(negedge clk);
        checks++;
        if (ex_to_mem_bus !== '0) begin
            errors++;
            $display("FAIL reset_mem_bus: got %h expected 0", ex_to_mem_bus);
        end
        checks++;
        if (stallreq_for_ex !== 1'b0) begin
            errors++;
            $display("FAIL reset_stallreq: got %b expected 0", stallreq_for_ex);
        end
        hi_m = 32'd0;
        lo_m = 32'd0;
        rst = 1'b1;
        id_to_ex_bus = mk_bus(32'h0, ALU_MFLO, DIV_NONE, 1'b0, 1'b0, 1'b1, 1'b1, 5'd3,
                              32'd0, 32'd0, 32'd0);
        @(negedge clk);
        checks++;
        if (ex_to_rf_bus !== {1'b1, 5'd3, 32'd0}) begin
            errors++;
            $display("FAIL reset_mflo: got %h expected %h", ex_to_rf_bus, {1'b1, 5'd3, 32'd0});
        end
    endtask

    task automatic test_alu_directed();
        logic [3:0]  ops [5] = '{ALU_ADD, ALU_SRA, ALU_SLTU, ALU_SLT, ALU_LUI};
        logic [31:0] as  [5] = '{32'd7, 32'd4, 32'd1, 32'd1, 32'd0};
        logic [31:0] bs  [5] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                 32'h0000_1234};
        logic [31:0] exs [5] = '{32'd4, 32'hF800_0000, 32'd1, 32'd0, 32'h1234_0000};
        stall = ST_RUN;
        for (int i = 0; i < 5; i++) begin
            id_to_ex_bus = mk_bus(32'h100 + 32'(i), ops[i], DIV_NONE, 1'b0, 1'b0, 1'b1, 1'b1,
                                  5'd1, as[i], bs[i], 32'd0);
            @(negedge clk);
            checks++;
            if (ex_to_rf_bus[31:0] !== exs[i]) begin
                errors++;
                $display("FAIL alu_directed[%0d]: got %h expected %h", i, ex_to_rf_bus[31:0],
                         exs[i]);
            end
        end
    endtask

    task automatic test_alu_random();
        logic [31:0] pc, a, b, sd, res;
        logic [3:0]  op;
        logic [1:0]  dop;
        logic        men, mwe, sel, we;
        logic [4:0]  wa;
        stall = ST_RUN;
        for (int i = 0; i < 60; i++) begin
            pc  = $urandom();
            a   = $urandom();
            b   = $urandom();
            sd  = $urandom();
            op  = 4'($urandom_range(0, 15));
            dop = ($urandom_range(0, 1) == 1) ? 2'b01 : DIV_NONE;
            men = 1'($urandom());
            mwe = 1'($urandom());
            sel = 1'($urandom());
            we  = 1'($urandom());
            wa  = 5'($urandom());
            id_to_ex_bus = mk_bus(pc, op, dop, men, mwe, sel, we, wa, a, b, sd);
            res = model_alu(op, a, b);
            @(negedge clk);
            checks++;
            if (ex_to_mem_bus !== exp_mem(pc, men, mwe, sel, we, wa, res)) begin
                errors++;
                $display("FAIL alu_random_mem[%0d] op=%0d: got %h expected %h", i, op,
                         ex_to_mem_bus, exp_mem(pc, men, mwe, sel, we, wa, res));
            end
            checks++;
            if ({ex_to_rf_bus, data_sram_addr, data_sram_wdata, stallreq_for_ex} !==
                {we, wa, res, res, sd, 1'b0}) begin
                errors++;
                $display("FAIL alu_random_rf[%0d]: got %h/%h/%h/%b expected %h/%h/%h/0", i,
                         ex_to_rf_bus, data_sram_addr, data_sram_wdata, stallreq_for_ex,
                         {we, wa, res}, res, sd);
            end
        end
    endtask

    task automatic test_div();
        int          cyc;
        logic [31:0] rb, lo, hi;
        logic        rt;
        run_div(DIV_S, 32'hFFFF_FFF9, 32'd2, cyc, rb, rt, lo, hi);
        model_div(DIV_S, 32'hFFFF_FFF9, 32'd2, lo_m, hi_m);
        checks++;
        if (cyc != 33) begin
            errors++;
            $display("FAIL div_stall_cycles: got %0d expected 33", cyc);
        end
        checks++;
        if (rb !== 32'd0) begin
            errors++;
            $display("FAIL div_result_zero: got %h expected 0", rb);
        end
        checks++;
        if (rt !== 1'b0) begin
            errors++;
            $display("FAIL div_no_retrigger: got %b expected 0", rt);
        end
        checks++;
        if (lo !== 32'hFFFF_FFFD) begin
            errors++;
            $display("FAIL div_lo: got %h expected fffffffd", lo);
        end
        checks++;
        if (hi !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL div_mfhi: got %h expected ffffffff", hi);
        end
    endtask

    task automatic test_div_by_zero();
        logic [1:0]  ops [3] = '{DIV_U, DIV_S, DIV_S};
        logic [31:0] as  [3] = '{32'd100, 32'h8000_0000, 32'hFFFF_FFFB};
        logic [31:0] bs  [3] = '{32'd0, 32'hFFFF_FFFF, 32'd0};
        logic [31:0] elo [3] = '{32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};
        logic [31:0] ehi [3] = '{32'd100, 32'd0, 32'hFFFF_FFFB};
        int          cyc;
        logic [31:0] rb, lo, hi;
        logic        rt;
        for (int i = 0; i < 3; i++) begin
            run_div(ops[i], as[i], bs[i], cyc, rb, rt, lo, hi);
            model_div(ops[i], as[i], bs[i], lo_m, hi_m);
            checks++;
            if ({lo, hi} !== {elo[i], ehi[i]}) begin
                errors++;
                $display("FAIL div_boundary[%0d]: got lo=%h hi=%h expected lo=%h hi=%h", i,
                         lo, hi, elo[i], ehi[i]);
            end
        end
    endtask

    task automatic test_stall_bubble();
        logic [31:0]             pc;
        logic [EX_TO_MEM_WD-1:0] exp;
        logic [159:0]            rnd;
        pc  = $urandom();
        exp = exp_mem(pc, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 32'h104);
        id_to_ex_bus = mk_bus(pc, ALU_ADD, DIV_NONE, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0,
                              32'h100, 32'h4, 32'hDEAD_BEEF);
        stall = ST_RUN;
        @(negedge clk);
        checks++;
        if ({data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata} !==
            {1'b1, 4'hF, 32'h104, 32'hDEAD_BEEF}) begin
            errors++;
            $display("FAIL store_req: got en=%b wen=%h addr=%h wdata=%h expected 1/f/104/deadbeef",
                     data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata);
        end
        rnd = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        id_to_ex_bus = rnd[ID_TO_EX_WD-1:0];
        stall = ST_HOLD;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({ex_to_mem_bus, data_sram_wdata} !== {exp, 32'hDEAD_BEEF}) begin
                errors++;
                $display("FAIL stall_hold[%0d]: got %h expected %h", i, ex_to_mem_bus, exp);
            end
        end
        stall = ST_BUBBLE;
        @(negedge clk);
        checks++;
        if ({ex_to_mem_bus, data_sram_en} !== '0) begin
            errors++;
            $display("FAIL stall_bubble: got %h en=%b expected 0", ex_to_mem_bus, data_sram_en);
        end
        stall = ST_HOLD;
        @(negedge clk);
        checks++;
        if (ex_to_mem_bus !== '0) begin
            errors++;
            $display("FAIL bubble_hold: got %h expected 0", ex_to_mem_bus);
        end
    endtask

    task automatic test_reset_mid_div();
        id_to_ex_bus = mk_bus(32'h3000, ALU_ADD, DIV_U, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,
                              32'd1000, 32'd3, 32'd0);
        stall = ST_RUN;
        @(negedge clk);
        stall = ST_HOLD;
        repeat (11) @(negedge clk);
        checks++;
        if (stallreq_for_ex !== 1'b1) begin
            errors++;
            $display("FAIL middiv_busy: got %b expected 1", stallreq_for_ex);
        end
        rst = 1'b0;
        @(negedge clk);
        hi_m = 32'd0;
        lo_m = 32'd0;
        checks++;
        if ({stallreq_for_ex, ex_to_mem_bus} !== '0) begin
            errors++;
            $display("FAIL middiv_reset: got stallreq=%b bus=%h expected 0/0", stallreq_for_ex,
                     ex_to_mem_bus);
        end
        rst = 1'b1;
        stall = ST_RUN;
        id_to_ex_bus = mk_bus(32'h3004, ALU_MFLO, DIV_NONE, 1'b0, 1'b0, 1'b1, 1'b1, 5'd4,
                              32'd0, 32'd0, 32'd0);
        @(negedge clk);
        checks++;
        if (ex_to_rf_bus[31:0] !== lo_m) begin
            errors++;
            $display("FAIL middiv_lo: got %h expected %h", ex_to_rf_bus[31:0], lo_m);
        end
        id_to_ex_bus = mk_bus(32'h3008, ALU_MFHI, DIV_NONE, 1'b0, 1'b0, 1'b1, 1'b1, 5'd5,
                              32'd0, 32'd0, 32'd0);
        @(negedge clk);
        checks++;
        if (ex_to_rf_bus[31:0] !== hi_m) begin
            errors++;
            $display("FAIL middiv_hi: got %h expected %h", ex_to_rf_bus[31:0], hi_m);
        end
    endtask

    task automatic test_div_random();
        logic [1:0]  op;
        logic [31:0] a, b, lo, hi, rb;
        int          cyc;
        logic        rt;
        for (int i = 0; i < 8; i++) begin
            op = ($urandom_range(0, 1) == 1) ? DIV_S : DIV_U;
            a  = $urandom();
            b  = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(1, 300)) : $urandom();
            if ((i % 3) == 1) begin
                b = 32'd0 - b;
            end
            run_div(op, a, b, cyc, rb, rt, lo, hi);
            model_div(op, a, b, lo_m, hi_m);
            checks++;
            if ({cyc, rb, rt} !== {32'd33, 32'd0, 1'b0}) begin
                errors++;
                $display("FAIL div_rand_timing[%0d]: cycles=%0d result=%h retrig=%b", i, cyc,
                         rb, rt);
            end
            checks++;
            if ({lo, hi} !== {lo_m, hi_m}) begin
                errors++;
                $display("FAIL div_rand[%0d] op=%b a=%h b=%h: got lo=%h hi=%h expected lo=%h hi=%h",
                         i, op, a, b, lo, hi, lo_m, hi_m);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        hi_m = 32'd0;
        lo_m = 32'd0;
        rst = 1'b0;
        stall = ST_RUN;
        id_to_ex_bus = '0;
        test_reset();
        test_alu_directed();
        test_alu_random();
        test_div();
        test_div_by_zero();
        test_stall_bubble();
        test_reset_mid_div();
        test_div_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
